// File: rtl/rate_sequencer.sv
// rate_sequencer: plays a captured colour sequence as timed rate/tone steps for the divider
module rate_sequencer #(
    parameter int          DWELL_CYCLES = 25000000,
    parameter int          GAP_CYCLES   = 5000000,
    parameter logic [23:0] RATE_BLUE    = 24'd1388,
    parameter logic [23:0] RATE_YELLOW  = 24'd1249,
    parameter logic [23:0] RATE_GREEN   = 24'd1332,
    parameter logic [23:0] RATE_RED     = 24'd1388
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [4:0]  seq_len,
    input  logic [31:0] seq_code,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [23:0] cfg_data,
    output logic [23:0] rate_out,
    output logic        tone_en,
    output logic [1:0]  cur_color,
    output logic [3:0]  step_idx,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, LOAD, TONE, GAP, DONE} state_t;
    localparam logic [31:0] DWELL_LD = 32'(DWELL_CYCLES - 1);
    localparam logic [31:0] GAP_LD   = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;
    state_t      state, state_n;
    logic [31:0] cnt, cnt_n, code, code_n;
    logic [4:0]  len, len_n;
    logic [23:0] tbl [4];
    logic [23:0] rate_n;
    logic [1:0]  color_n, code_cur;
    logic [3:0]  idx_n;
    logic        tone_n, busy_n, done_n, last;
    assign code_cur = code[{step_idx, 1'b0} +: 2];
    assign last     = {1'b0, step_idx} == len - 5'd1;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        code_n  = code;
        len_n   = len;
        rate_n  = rate_out;
        color_n = cur_color;
        idx_n   = step_idx;
        tone_n  = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: if (start) begin
                code_n  = seq_code;
                len_n   = (seq_len > 5'd16) ? 5'd16 : seq_len;
                idx_n   = 4'd0;
                state_n = (seq_len == 5'd0) ? DONE : LOAD;
                busy_n  = seq_len != 5'd0;
                done_n  = seq_len == 5'd0;
            end
            LOAD: begin
                rate_n  = tbl[code_cur];
                color_n = code_cur;
                cnt_n   = DWELL_LD;
                state_n = TONE;
                tone_n  = 1'b1;
                busy_n  = 1'b1;
            end
            TONE: if (cnt != 32'd0) begin
                cnt_n  = cnt - 32'd1;
                tone_n = 1'b1;
                busy_n = 1'b1;
            end else if (last) begin
                state_n = DONE;
                done_n  = 1'b1;
            end else if (GAP_CYCLES > 0) begin
                state_n = GAP;
                cnt_n   = GAP_LD;
                busy_n  = 1'b1;
            end else begin
                state_n = LOAD;
                idx_n   = step_idx + 4'd1;
                busy_n  = 1'b1;
            end
            GAP: begin
                busy_n = 1'b1;
                if (cnt != 32'd0) cnt_n = cnt - 32'd1;
                else begin
                    state_n = LOAD;
                    idx_n   = step_idx + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (abort && (state == LOAD || state == TONE || state == GAP)) begin
            state_n = IDLE;
            cnt_n   = 32'd0;
            rate_n  = rate_out;
            color_n = cur_color;
            idx_n   = step_idx;
            tone_n  = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        assert (DWELL_CYCLES >= 1);
        if (reset) begin
            state     <= IDLE;
            cnt       <= 32'd0;
            code      <= 32'd0;
            len       <= 5'd0;
            rate_out  <= 24'd0;
            cur_color <= 2'd0;
            step_idx  <= 4'd0;
            tone_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tbl[0]    <= RATE_BLUE;
            tbl[1]    <= RATE_YELLOW;
            tbl[2]    <= RATE_GREEN;
            tbl[3]    <= RATE_RED;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            code      <= code_n;
            len       <= len_n;
            rate_out  <= rate_n;
            cur_color <= color_n;
            step_idx  <= idx_n;
            tone_en   <= tone_n;
            busy      <= busy_n;
            done      <= done_n;
            if (cfg_we) tbl[cfg_addr] <= cfg_data;
        end
    end
endmodule
